// File: rtl/map_renderer.sv
// Walks the maze tile by tile (column-major) and plots each tile as a TILE x TILE block.
// Optional MAP_RENDERER_PELLET_EN: empty tiles get a centre pellet pixel in PELLET_COLOUR.
module map_renderer #(
    parameter int          MAP_W       = 27,
    parameter int          MAP_H       = 24,
    parameter int          TILE        = 4,
    parameter logic [7:0]  X0          = 8'd26,
    parameter logic [6:0]  Y0          = 7'd12,
    parameter logic [2:0]  WALL_COLOUR = 3'b001,
    parameter logic [2:0]  BG_COLOUR   = 3'b000
`ifdef MAP_RENDERER_PELLET_EN
  , parameter logic [2:0]  PELLET_COLOUR = 3'b110
`endif
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic [7:0] map_x,
    output logic [6:0] map_y,
    input  logic       map_q,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);
    localparam int OW = (TILE > 1) ? $clog2(TILE) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAW, DONE} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   ox_q, ox_d, oy_q, oy_d;
    logic            wall_q, wall_d;
    logic [7:0]      map_x_q, map_x_d;
    logic [6:0]      map_y_q, map_y_d;
    logic [7:0]      vga_x_q, vga_x_d;
    logic [6:0]      vga_y_q, vga_y_d;
    logic [2:0]      vga_colour_q, vga_colour_d;
    logic            vga_plot_q, vga_plot_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // Offsets and wall bit of the pixel that appears on the outputs next cycle
    logic [OW-1:0]   px_ox, px_oy;
    logic            px_wall;

    always_comb begin
        state_d      = state_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        wall_d       = wall_q;
        map_x_d      = map_x_q;
        map_y_d      = map_y_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        px_ox        = '0;
        px_oy        = '0;
        px_wall      = wall_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    map_x_d = '0;
                    map_y_d = '0;
                end
            end
            FETCH: begin
                // The lookup is combinational, so the first pixel of the tile
                // is issued straight from map_q while it is also latched.
                wall_d     = map_q;
                ox_d       = '0;
                oy_d       = '0;
                state_d    = DRAW;
                vga_plot_d = 1'b1;
                px_wall    = map_q;
            end
            DRAW: begin
                if (ox_q == OW'(TILE-1) && oy_q == OW'(TILE-1)) begin
                    if (map_x_q == 8'(MAP_W-1) && map_y_q == 7'(MAP_H-1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = FETCH;
                        if (map_y_q == 7'(MAP_H-1)) begin
                            map_y_d = '0;
                            map_x_d = map_x_q + 8'd1;
                        end else begin
                            map_y_d = map_y_q + 7'd1;
                        end
                    end
                end else begin
                    if (ox_q == OW'(TILE-1)) begin
                        ox_d = '0;
                        oy_d = oy_q + 1'b1;
                    end else begin
                        ox_d = ox_q + 1'b1;
                    end
                    vga_plot_d = 1'b1;
                    px_ox      = ox_d;
                    px_oy      = oy_d;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (vga_plot_d) begin
            vga_x_d      = 8'(int'(X0) + int'(map_x_q) * TILE + int'(px_ox));
            vga_y_d      = 7'(int'(Y0) + int'(map_y_q) * TILE + int'(px_oy));
            vga_colour_d = px_wall ? WALL_COLOUR : BG_COLOUR;
`ifdef MAP_RENDERER_PELLET_EN
            if (!px_wall && int'(px_ox) == TILE/2 && int'(px_oy) == TILE/2)
                vga_colour_d = PELLET_COLOUR;
`endif
        end

        busy_d = (state_d == FETCH) || (state_d == DRAW);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            ox_q         <= '0;
            oy_q         <= '0;
            wall_q       <= 1'b0;
            map_x_q      <= '0;
            map_y_q      <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            wall_q       <= wall_d;
            map_x_q      <= map_x_d;
            map_y_q      <= map_y_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign map_x      = map_x_q;
    assign map_y      = map_y_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
endmodule

// File: tb/tb_map_renderer.sv
// Self-checking bench for map_renderer: frame-level model of plot order and timing.
module tb_map_renderer;
    localparam int MAP_W = 27;
    localparam int MAP_H = 24;
    localparam int TILE  = 4;
    localparam int X0    = 26;
    localparam int Y0    = 12;
    localparam int PER_TILE = 1 + TILE*TILE;
    localparam int BUSY_CYC = MAP_W*MAP_H*PER_TILE;
    localparam int N_PLOTS  = MAP_W*MAP_H*TILE*TILE;
`ifdef MAP_RENDERER_PELLET_EN
    localparam bit PELLET = 1'b1;
`else
    localparam bit PELLET = 1'b0;
`endif

    logic       clk, resetn, start;
    logic       busy, done, map_q, vga_plot;
    logic [7:0] map_x, vga_x;
    logic [6:0] map_y, vga_y;
    logic [2:0] vga_colour;

    map_renderer dut (
        .clk(clk), .resetn(resetn), .start(start),
        .busy(busy), .done(done),
        .map_x(map_x), .map_y(map_y), .map_q(map_q),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    // Stand-in maze: odd columns are walls except rows y%3==1.
    function automatic logic tb_wall(input logic [7:0] x, input logic [6:0] y);
        return (x[0] == 1'b1) && ((int'(y) % 3) != 1);
    endfunction
    assign map_q = tb_wall(map_x, map_y);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int x; int y; int c; } pix_t;
    pix_t exp_q[$];
    bit   drawn [160][120];
    bit   active = 1'b0;
    int   start_n = 0;
    int   plots, dups, t10_cnt, t00_bg;

    task automatic build_model();
        exp_q.delete();
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++) drawn[i][j] = 1'b0;
        plots = 0; dups = 0; t10_cnt = 0; t00_bg = 0;
        for (int tx = 0; tx < MAP_W; tx++)
            for (int ty = 0; ty < MAP_H; ty++)
                for (int oy = 0; oy < TILE; oy++)
                    for (int ox = 0; ox < TILE; ox++) begin
                        pix_t p;
                        p.x = X0 + tx*TILE + ox;
                        p.y = Y0 + ty*TILE + oy;
                        if (tb_wall(8'(tx), 7'(ty))) p.c = 1;
                        else if (PELLET && ox == TILE/2 && oy == TILE/2) p.c = 6;
                        else p.c = 0;
                        exp_q.push_back(p);
                    end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},   int'(busy), 0);
        chk({tag, "_done"},   int'(done), 0);
        chk({tag, "_plot"},   int'(vga_plot), 0);
        chk({tag, "_vga_x"},  int'(vga_x), 0);
        chk({tag, "_vga_y"},  int'(vga_y), 0);
        chk({tag, "_colour"}, int'(vga_colour), 0);
        chk({tag, "_map_x"},  int'(map_x), 0);
        chk({tag, "_map_y"},  int'(map_y), 0);
    endtask

    // Compare process: k counts cycles after the cycle in which start was sampled.
    always @(negedge clk) begin
        if (active && resetn) begin
            int k;
            k = cyc - start_n;
            if (k >= 1 && k <= BUSY_CYC + 1) begin
                bit e_plot;
                e_plot = (k >= 2) && (k <= BUSY_CYC) && (((k - 1) % PER_TILE) != 0);
                chk("busy", int'(busy), (k <= BUSY_CYC) ? 1 : 0);
                chk("done", int'(done), (k == BUSY_CYC + 1) ? 1 : 0);
                chk("plot", int'(vga_plot), e_plot ? 1 : 0);
                if (vga_plot) begin
                    int x, y, c;
                    x = int'(vga_x); y = int'(vga_y); c = int'(vga_colour);
                    if (plots == 0) begin
                        chk("first_x", x, 26);
                        chk("first_y", y, 12);
                        chk("first_colour", c, 0);
                    end
                    if (x >= 30 && x <= 33 && y >= 12 && y <= 15) begin
                        chk("tile10_colour", c, 1);
                        t10_cnt++;
                    end
                    if (x >= 26 && x <= 29 && y >= 12 && y <= 15) begin
                        chk("tile00_colour", c, (PELLET && x == 28 && y == 14) ? 6 : 0);
                        if (c == 0) t00_bg++;
                    end
                    if (exp_q.size() > 0) begin
                        pix_t p;
                        p = exp_q.pop_front();
                        chk("pix_x", x, p.x);
                        chk("pix_y", y, p.y);
                        chk("pix_colour", c, p.c);
                    end
                    if (x < 160 && y < 120) begin
                        if (drawn[x][y]) dups++;
                        drawn[x][y] = 1'b1;
                    end
                    plots++;
                end
            end
            if (k == BUSY_CYC + 2) begin
                chk("idle_busy", int'(busy), 0);
                chk("idle_done", int'(done), 0);
                chk("plot_count", plots, N_PLOTS);
                chk("dup_pixels", dups, 0);
                chk("tile10_count", t10_cnt, TILE*TILE);
                chk("tile00_bg_count", t00_bg, PELLET ? 15 : 16);
                active = 1'b0;
            end
        end
    end

    task automatic run_frame(input bit mid_pulse, input bit reset_mid);
        @(negedge clk);
        start = 1'b1;
        start_n = cyc;
        build_model();
        active = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < BUSY_CYC + 100 && active; i++) begin
            @(negedge clk);
            start = (mid_pulse && cyc == start_n + 500);
            if (reset_mid && cyc == start_n + 3000) begin
                active = 1'b0;
                resetn = 1'b0;
                #1;
                check_reset_vals("midrst");
                @(negedge clk);
                resetn = 1'b1;
            end
        end
        chk("frame_end", int'(active), 0);
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        resetn = 1'b1;
        repeat (100) begin
            @(negedge clk);
            chk("idle_plot", int'(vga_plot), 0);
            chk("idle_busy", int'(busy), 0);
            chk("idle_done", int'(done), 0);
        end
        run_frame(1'b0, 1'b0);
        repeat (5) @(negedge clk);
        run_frame(1'b1, 1'b0);
        repeat (5) @(negedge clk);
        run_frame(1'b0, 1'b1);
        repeat (5) @(negedge clk);
        run_frame(1'b0, 1'b0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
